guess_tracker: RTL and testbench
================================

// Module: guess_tracker
// PURPOSE
//  Upstream companion to the difficulty/win-lose FSM. Holds the secret number for
//  the current level and checks the player's switch-entered guess on each confirm
//  press. Maintains the round, incorrect-guess and countdown-timer counts that the
//  FSM consumes, plus a confirm pulse aligned with those updated counts.
//  Reads max_digit back from the FSM to size the guess range per level.
// PARAMETERS
//  TICK_DIV     50_000_000  clk cycles per timer tick (1 s at 50 MHz); must be >=2
//  TIMER_START  7'd99       timer reload value (0..127)
// PORTS
//  clk               in   1   system clock; all state on posedge
//  restart           in   1   reset, asynchronous, active-low
//  confirm_btn       in   1   raw confirm button level, asynchronous to clk
//  guess             in   10  player guess, unsigned binary
//  max_digit         in   2   level digit count from FSM; 1..3 = active level, 0 = game ended
//  incorrect_guesses out  3   wrong guesses this level, saturating
//  round             out  3   correct guesses this level, saturating
//  timer             out  7   remaining seconds this level
//  confirm_out       out  1   1-cycle pulse; counters already reflect this guess
//  too_high          out  1   last checked guess > target (held)
//  too_low           out  1   last checked guess < target (held)
//  target            out  10  current secret number (debug/display)
// BEHAVIOUR
//  Reset (restart=0, async): state IDLE, counters 0, timer=TIMER_START.
//   confirm_out/too_high/too_low 0, target 0, lfsr 10'h001, prescaler 0, prev_digit 0.
//  LFSR
//   - 10-bit Fibonacci, taps x^10+x^7+1, steps every cycle in all states.
//   - Never 0; candidate = lfsr-1 (0..1022).
//  LIMIT = 10 / 100 / 1000 for max_digit 1 / 2 / 3.
//  Button input
//   - confirm_btn passes through a 2-flop synchroniser.
//   - Rising edge of the synchronised level gives press (1 cycle).
//   - Press is at most 3 cycles after the pin rises.
//  Level change: registered prev_digit; event when max_digit != prev_digit.
//   - To nonzero: round=0, incorrect=0, timer=TIMER_START, prescaler=0.
//     Hint flags cleared; state -> GEN.
//   - To 0: state -> HALT. All counters and outputs frozen; presses ignored.
//   - Level change has priority; a press in the same cycle is dropped.
//  States
//   IDLE: wait for a level event. Presses ignored.
//   GEN: each cycle, if candidate < LIMIT then target <= candidate, -> PLAY.
//    Otherwise stay. Exit bound: within 1023 cycles. Presses ignored.
//   PLAY: prescaler counts 0..TICK_DIV-1 and wraps.
//    - On wrap, timer decrements if >0 and holds at 0 (no wrap).
//    - On press in cycle E, all of the following appear at E+1:
//      - confirm_out=1.
//      - If guess==target: round+1 (sat 7), flags cleared, -> GEN.
//        Timer and prescaler keep running.
//      - Else: incorrect+1 (sat 7). too_high=(guess>target), too_low=!too_high.
//      - guess>=LIMIT counts as incorrect with too_high=1.
//    - Guesses are still checked when timer==0; the FSM decides the loss.
//    - Tick and press in the same cycle are both applied.
//   HALT: left only by a level event to nonzero, or by reset.
//  confirm_out is exactly 1 cycle wide; never asserted outside PLAY.
//  Reset mid-game returns to IDLE immediately. No partial count survives.
// TESTING
//  1 Reset, max_digit 0->1, TICK_DIV=4, TIMER_START=5.
//    -> GEN then PLAY. target<10, round=0, timer=5.
//  2 PLAY, guess=target, pulse btn.
//    -> within 4 cycles confirm_out 1 cycle; round 0->1; incorrect=0; GEN re-entered.
//  3 guess=target+1, then target-1.
//    -> incorrect 1, too_high; then incorrect 2, too_low. Round unchanged.
//  4 No presses for 30 cycles.
//    -> timer 5,4,..,0 every 4 cycles; stays 0. Press at 0 still gives confirm_out.
//  5 max_digit 1->2 while round=5, incorrect=3.
//    -> round=0, incorrect=0, timer=5; new target<100. Simultaneous press gives no confirm_out.
//  6 max_digit ->0, then press; also restart low mid-PLAY.
//    -> HALT: outputs frozen, no confirm_out. Restart: all outputs to reset values async.

Source files
------------

// File: rtl/guess_tracker.sv
// Secret-number holder and guess checker feeding the difficulty/win-lose FSM.
// Tracks round, wrong-guess and countdown counts per level and emits an aligned confirm pulse.
module guess_tracker #(
    parameter int         TICK_DIV    = 50_000_000,
    parameter logic [6:0] TIMER_START = 7'd99
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       confirm_btn,
    input  logic [9:0] guess,
    input  logic [1:0] max_digit,
    output logic [2:0] incorrect_guesses,
    output logic [2:0] round,
    output logic [6:0] timer,
    output logic       confirm_out,
    output logic       too_high,
    output logic       too_low,
    output logic [9:0] target
);

    localparam int             PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        PLAY = 2'd2,
        HALT = 2'd3
    } state_t;

    function automatic logic [9:0] level_limit(input logic [1:0] digits);
        logic [9:0] lim;
        case (digits)
            2'd1:    lim = 10'd10;
            2'd2:    lim = 10'd100;
            2'd3:    lim = 10'd1000;
            default: lim = 10'd0;
        endcase
        return lim;
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] value);
        logic [2:0] next;
        if (value == 3'd7) begin
            next = 3'd7;
        end else begin
            next = value + 3'd1;
        end
        return next;
    endfunction

    state_t        state_r;
    logic          sync1_r;
    logic          sync2_r;
    logic          sync3_r;
    logic [9:0]    lfsr_r;
    logic [1:0]    prev_digit_r;
    logic [PW-1:0] prescaler_r;

    logic          press_s;
    logic          level_evt_s;
    logic          tick_s;
    logic          guess_high_s;
    logic [9:0]    limit_s;
    logic [9:0]    candidate_s;

    // Decode press edge, level events, timer tick and guess comparison.
    always_comb begin
        press_s     = sync2_r & ~sync3_r;
        level_evt_s = (max_digit != prev_digit_r);
        limit_s     = level_limit(max_digit);
        candidate_s = lfsr_r - 10'd1;
        tick_s      = (prescaler_r == PRE_LAST);
        // Out-of-range guesses are always reported as too high.
        if (guess >= limit_s) begin
            guess_high_s = 1'b1;
        end else begin
            guess_high_s = (guess > target);
        end
    end

    // Button synchroniser with edge-detect stage, and free-running LFSR.
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            lfsr_r  <= 10'h001;
        end else begin
            sync1_r <= confirm_btn;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            lfsr_r  <= {lfsr_r[8:0], lfsr_r[9] ^ lfsr_r[6]};
        end
    end

    // Game state machine with registered counters, hints and confirm pulse.
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state_r           <= IDLE;
            prev_digit_r      <= 2'd0;
            prescaler_r       <= '0;
            round             <= 3'd0;
            incorrect_guesses <= 3'd0;
            timer             <= TIMER_START;
            confirm_out       <= 1'b0;
            too_high          <= 1'b0;
            too_low           <= 1'b0;
            target            <= 10'd0;
        end else begin
            confirm_out  <= 1'b0;
            prev_digit_r <= max_digit;
            if (level_evt_s) begin
                if (max_digit != 2'd0) begin
                    round             <= 3'd0;
                    incorrect_guesses <= 3'd0;
                    timer             <= TIMER_START;
                    prescaler_r       <= '0;
                    too_high          <= 1'b0;
                    too_low           <= 1'b0;
                    state_r           <= GEN;
                end else begin
                    state_r <= HALT;
                end
            end else begin
                // The countdown keeps running while a fresh secret is drawn.
                if (state_r == GEN || state_r == PLAY) begin
                    if (tick_s) begin
                        prescaler_r <= '0;
                        if (timer != 7'd0) begin
                            timer <= timer - 7'd1;
                        end
                    end else begin
                        prescaler_r <= prescaler_r + PW'(1);
                    end
                end
                case (state_r)
                    IDLE: state_r <= IDLE;
                    HALT: state_r <= HALT;
                    GEN: begin
                        if (candidate_s < limit_s) begin
                            target  <= candidate_s;
                            state_r <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (press_s) begin
                            confirm_out <= 1'b1;
                            if (guess == target) begin
                                round    <= sat_inc(round);
                                too_high <= 1'b0;
                                too_low  <= 1'b0;
                                state_r  <= GEN;
                            end else begin
                                incorrect_guesses <= sat_inc(incorrect_guesses);
                                too_high          <= guess_high_s;
                                too_low           <= ~guess_high_s;
                            end
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_tracker.sv
// Scoreboard bench for guess_tracker: presses push expected counters, a monitor pops on confirm_out.
module tb_guess_tracker;

    typedef struct packed {
        logic [2:0] rnd;
        logic [2:0] inc;
        logic       hi;
        logic       lo;
    } resp_t;

    logic       clk = 1'b0;
    logic       restart;
    logic       confirm_btn;
    logic [9:0] guess;
    logic [1:0] max_digit;
    logic [2:0] incorrect_guesses;
    logic [2:0] round;
    logic [6:0] timer;
    logic       confirm_out;
    logic       too_high;
    logic       too_low;
    logic [9:0] target;

    int    checks   = 0;
    int    passed   = 0;
    int    conf_cnt = 0;
    logic  prev_conf = 1'b0;
    resp_t exp_q[$];
    resp_t mon_e;
    logic [2:0] rnd_m;
    logic [2:0] inc_m;

    guess_tracker #(.TICK_DIV(4), .TIMER_START(7'd5)) dut (
        .clk               (clk),
        .restart           (restart),
        .confirm_btn       (confirm_btn),
        .guess             (guess),
        .max_digit         (max_digit),
        .incorrect_guesses (incorrect_guesses),
        .round             (round),
        .timer             (timer),
        .confirm_out       (confirm_out),
        .too_high          (too_high),
        .too_low           (too_low),
        .target            (target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every confirm pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (confirm_out) begin
            conf_cnt <= conf_cnt + 1;
            if (prev_conf) check("pulse_width", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_confirm", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("confirm_resp", int'({round, incorrect_guesses, too_high, too_low}), int'(mon_e));
            end
        end
        prev_conf <= confirm_out;
    end

    task automatic press(input logic [9:0] g, input logic expect_resp, input resp_t e);
        int c0;
        guess = g;
        @(posedge clk); #1;
        if (expect_resp) exp_q.push_back(e);
        c0 = conf_cnt;
        confirm_btn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("confirm_latency", conf_cnt - c0, expect_resp ? 1 : 0);
        confirm_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wrong(input logic [9:0] g, input int lim);
        logic hi;
        hi = (int'(g) >= lim) || (g > target);
        inc_m = (inc_m == 3'd7) ? 3'd7 : inc_m + 3'd1;
        press(g, 1'b1, {rnd_m, inc_m, hi, ~hi});
    endtask

    task automatic correct();
        rnd_m = (rnd_m == 3'd7) ? 3'd7 : rnd_m + 3'd1;
        press(target, 1'b1, {rnd_m, inc_m, 2'b00});
        repeat (1030) @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        int   c0;
        logic [9:0] t;
        restart = 1'b1; confirm_btn = 1'b0; guess = 10'd0; max_digit = 2'd0;
        rnd_m = 3'd0; inc_m = 3'd0;
        #1 restart = 1'b0;
        #2;
        check("rst_round", round, 0);
        check("rst_incorrect", incorrect_guesses, 0);
        check("rst_timer", timer, 5);
        check("rst_confirm", confirm_out, 0);
        check("rst_flags", {too_high, too_low}, 0);
        check("rst_target", target, 0);
        repeat (2) @(posedge clk);
        #1 restart = 1'b1;
        repeat (3) @(posedge clk);
        #1 max_digit = 2'd1;
        @(posedge clk); #1;
        check("lvl1_timer", timer, 5);
        check("lvl1_round", round, 0);

        // Countdown: one step every 4 cycles, then holds at 0.
        n = 0;
        while (timer == 7'd5 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("timer_first_tick", timer, 4);
        for (int k = 3; k >= 0; k--) begin
            repeat (3) @(posedge clk);
            #1 check("timer_hold", timer, k + 1);
            @(posedge clk);
            #1 check("timer_step", timer, k);
        end
        repeat (12) @(posedge clk);
        #1 check("timer_sat_zero", timer, 0);

        repeat (1030) @(posedge clk);
        #1 check("target_lt_10", int'(target < 10'd10), 1);

        // Wrong guesses above and below, at timer 0.
        t = target;
        wrong(t + 10'd1, 10);
        if (t != 10'd0) wrong(t - 10'd1, 10);
        else wrong(t + 10'd3, 10);
        correct();
        for (int i = 0; i < 4; i++) correct();
        wrong(10'd1023, 10);

        // Level change with a coincident press: counters reset, press dropped.
        c0 = conf_cnt;
        guess = target;
        @(posedge clk); #1 confirm_btn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 max_digit = 2'd2;
        @(posedge clk); #1;
        check("lvl2_round", round, 0);
        check("lvl2_incorrect", incorrect_guesses, 0);
        check("lvl2_timer", timer, 5);
        check("lvl2_flags", {too_high, too_low}, 0);
        confirm_btn = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("dropped_press", conf_cnt - c0, 0);
        rnd_m = 3'd0; inc_m = 3'd0;
        repeat (1030) @(posedge clk);
        #1 check("target_lt_100", int'(target < 10'd100), 1);
        for (int i = 0; i < 8; i++) wrong(10'd1023, 100);
        correct();

        // Game end: everything frozen, presses ignored.
        max_digit = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        press(target, 1'b0, 8'd0);
        repeat (10) @(posedge clk);
        #1;
        check("halt_round", round, int'(rnd_m));
        check("halt_incorrect", incorrect_guesses, 7);
        check("halt_timer", timer, 0);
        check("halt_flags", {too_high, too_low}, 0);

        // Leave HALT into level 1, then reset mid-play.
        max_digit = 2'd1;
        @(posedge clk); #1;
        check("rehalt_round", round, 0);
        check("rehalt_timer", timer, 5);
        rnd_m = 3'd0; inc_m = 3'd0;
        repeat (1030) @(posedge clk);
        #1;
        wrong(10'd1023, 10);
        @(posedge clk);
        #2 restart = 1'b0;
        #1;
        check("arst_round", round, 0);
        check("arst_incorrect", incorrect_guesses, 0);
        check("arst_timer", timer, 5);
        check("arst_target", target, 0);
        check("arst_flags", {too_high, too_low, confirm_out}, 0);
        repeat (2) @(posedge clk);
        #1 restart = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
